// File: rtl/seq_mul4_if.sv
// Operand/result bundle between a requester and the seq_mul4 shift-and-add multiplier.
// The requester owns start and the operands; the multiplier owns busy, done and the product.
interface seq_mul4_if #(
  parameter int W = 4
);
  logic             start_i;
  logic [W-1:0]     x_i;
  logic [W-1:0]     y_i;
  logic             busy_o;
  logic             done_o;
  logic [2*W-1:0]   p_o;

  modport master (
    output start_i, x_i, y_i,
    input  busy_o, done_o, p_o
  );

  modport slave (
    input  start_i, x_i, y_i,
    output busy_o, done_o, p_o
  );
endinterface

// File: rtl/seq_mul4.sv
// Sequential unsigned shift-and-add multiplier: A and Q shift right as one chain,
// one partial-product step per cycle, with a registered 2W-bit product and a done strobe.
module seq_mul4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  seq_mul4_if.slave    bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [W-1:0]     m_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     q_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   p_q;
  logic             busy_q;
  logic             done_q;

  logic [W:0]       sum_d;
  logic [W-1:0]     a_d;
  logic [W-1:0]     q_d;
  logic             last_d;

  // One step: conditional add (carry kept in sum_d[W]) then the joint right shift of A:Q.
  always_comb begin
    sum_d  = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : {(W + 1){1'b0}});
    a_d    = sum_d[W:1];
    q_d    = {sum_d[0], q_q[W-1:1]};
    last_d = (cnt_q == CW'(W - 1));
  end

  // Control FSM and datapath registers; busy/done decoded into flops so they never glitch.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      m_q     <= {W{1'b0}};
      a_q     <= {W{1'b0}};
      q_q     <= {W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      p_q     <= {(2 * W){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            m_q     <= bus.x_i;
            q_q     <= bus.y_i;
            a_q     <= {W{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          // p only changes on the final step, so it never exposes a partial product.
          if (last_d) begin
            p_q     <= {a_d, q_d};
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            done_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.p_o    = p_q;

endmodule

// File: tb/tb_seq_mul4.sv
// Self-checking bench for seq_mul4: directed cases, exhaustive sweep and random operations,
// with expected products queued at accept time and popped by an independent done monitor.
module tb_seq_mul4;

  localparam int W = 4;

  logic clk;
  logic rst_b;
  int   checks;
  int   failures;
  int   cyc;
  int   exp_q[$];
  int   model_p;
  bit   held_mode;
  bit   held_seen;
  int   last_done_cyc;

  seq_mul4_if #(.W(W)) bus ();

  seq_mul4 #(.W(W)) u_dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pops one expected product; done must be a single cycle.
  initial begin
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_b && bus.done_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("product", bus.p_o, exp_q.pop_front());
        end
        chk("done_single_cycle", prev_done, 0);
        chk("busy_with_done", bus.busy_o, 1);
        if (held_mode && held_seen) chk("held_spacing", cyc - last_done_cyc, W + 2);
        held_seen     = 1'b1;
        last_done_cyc = cyc;
      end
      prev_done = rst_b ? bus.done_o : 1'b0;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) begin
      chk("idle_timeout", 1, 0);
    end
  endtask

  // One full operation with latency, busy-width and p-hold checks.
  task automatic do_op(input int xv, input int yv, input bit scramble);
    int lat;
    int busy_n;
    wait_idle();
    bus.start_i = 1'b1;
    bus.x_i     = xv[W-1:0];
    bus.y_i     = yv[W-1:0];
    @(posedge clk);
    exp_q.push_back(xv * yv);
    #1;
    bus.start_i = 1'b0;
    if (scramble) begin
      bus.x_i = W'($urandom);
      bus.y_i = W'($urandom);
    end
    lat    = -1;
    busy_n = 0;
    for (int j = 0; j < W + 6; j++) begin
      @(negedge clk);
      if (j < W) chk("p_hold", bus.p_o, model_p);
      if (bus.busy_o) busy_n++;
      if (bus.done_o && lat < 0) lat = j;
      if (!bus.busy_o) break;
    end
    chk("done_latency", lat, W);
    chk("busy_cycles", busy_n, W + 1);
    model_p = xv * yv;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    model_p       = 0;
    held_mode     = 1'b0;
    held_seen     = 1'b0;
    last_done_cyc = 0;
    rst_b         = 1'b0;
    bus.start_i   = 1'b0;
    bus.x_i       = 4'd0;
    bus.y_i       = 4'd0;
    #12;
    chk("reset_p", bus.p_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_done", bus.done_o, 0);
    @(negedge clk);
    rst_b = 1'b1;

    do_op(3, 5, 1'b0);
    do_op(15, 15, 1'b0);
    do_op(0, 9, 1'b0);
    do_op(9, 0, 1'b0);

    // Operands change right after the accept edge.
    wait_idle();
    bus.start_i = 1'b1;
    bus.x_i = 4'd2;
    bus.y_i = 4'd11;
    @(posedge clk);
    exp_q.push_back(22);
    #1;
    bus.start_i = 1'b0;
    bus.x_i = 4'd13;
    bus.y_i = 4'd4;
    model_p = 22;

    // start pulses mid-CALC and during DONE are ignored.
    wait_idle();
    bus.start_i = 1'b1;
    bus.x_i = 4'd3;
    bus.y_i = 4'd5;
    @(posedge clk);
    exp_q.push_back(15);
    #1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.x_i = 4'd1;
    bus.y_i = 4'd1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.x_i = 4'd2;
    bus.y_i = 4'd2;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("ignored_start_busy0", bus.busy_o, 0);
    @(negedge clk);
    chk("ignored_start_busy1", bus.busy_o, 0);
    chk("ignored_start_p", bus.p_o, 15);
    model_p = 15;

    // start held high: one accept every W+2 cycles.
    wait_idle();
    held_mode = 1'b1;
    held_seen = 1'b0;
    bus.start_i = 1'b1;
    bus.x_i = 4'd5;
    bus.y_i = 4'd12;
    for (int k = 0; k < 3; k++) exp_q.push_back(60);
    for (int c = 0; c < 2 * (W + 2) + 1; c++) @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    wait_idle();
    held_mode = 1'b0;
    model_p = 60;

    // Reset during CALC aborts the operation with no done.
    wait_idle();
    bus.start_i = 1'b1;
    bus.x_i = 4'd7;
    bus.y_i = 4'd6;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    chk("abort_p", bus.p_o, 0);
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_done", bus.done_o, 0);
    model_p = 0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (W + 3) @(negedge clk);
    do_op(7, 6, 1'b0);

    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        do_op(a, b, 1'b0);
      end
    end

    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)), 1'b1);
    end

    repeat (W + 4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
